// File: rtl/lvds_link_pkg.sv
// rtl/lvds_link_pkg.sv - shared LVDS link framing constants and scheduler state encoding
// Used by both the TX frame scheduler and the receiver-side deframer.
package lvds_link_pkg;

  localparam int         N_CH     = 2;
  localparam logic [7:0] COMMA_8B = 8'hBC;
  localparam logic [7:0] HDR_SYNC = 8'hEE;
  localparam logic [7:0] TAG_BASE = 8'h33;
  localparam logic [7:0] PAD_BYTE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_LEN,
    ST_PAYLOAD
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with last-served pointer
// The pointer moves only when the caller commits a grant via take.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic last_one;  // 1 when channel 1 was served last; reset value favours channel 0

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_one)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_one <= 1'b1;
    end else if (take) begin
      last_one <= gnt[1];
    end
  end

endmodule

// File: rtl/lvds_tx_frame_sched.sv
// rtl/lvds_tx_frame_sched.sv - two-channel frame scheduler feeding the 8b/10b encoder
// Each output symbol is registered on the edge that leaves the state producing it.
module lvds_tx_frame_sched #(
  parameter logic [7:0] IDLE_GAP = 8'd16,
  parameter logic [7:0] HDR_SYNC = lvds_link_pkg::HDR_SYNC,
  parameter logic [7:0] TAG_BASE = lvds_link_pkg::TAG_BASE,
  parameter logic [7:0] PAD_BYTE = lvds_link_pkg::PAD_BYTE,
  parameter logic [7:0] COMMA_8B = lvds_link_pkg::COMMA_8B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       link_en,
  input  logic [1:0] req,
  input  logic [7:0] len0,
  input  logic [7:0] len1,
  input  logic [7:0] s_data0,
  input  logic [7:0] s_data1,
  input  logic [1:0] s_valid,
  output logic [1:0] s_ready,
  output logic [1:0] grant,
  output logic [1:0] frame_done,
  output logic       underrun,
  output logic [7:0] tx_data,
  output logic       tx_k,
  output logic       busy
);

  import lvds_link_pkg::*;

  state_t     state, state_n;
  logic [7:0] rem, rem_n;
  logic [7:0] gap, gap_n;
  logic [7:0] tx_data_n;
  logic       tx_k_n, underrun_n, arb_take, beat_ok;
  logic [1:0] grant_n, frame_done_n, arb_gnt;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .take  (arb_take),
    .gnt   (arb_gnt)
  );

  assign s_ready = (state == ST_PAYLOAD && rem != 8'd0) ? grant : 2'b00;
  assign beat_ok = |(s_valid & s_ready);

  always_comb begin
    state_n      = state;
    rem_n        = rem;
    gap_n        = gap;
    grant_n      = grant;
    tx_data_n    = COMMA_8B;
    tx_k_n       = 1'b1;
    frame_done_n = 2'b00;
    underrun_n   = 1'b0;
    arb_take     = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_n = 2'b00;
        if (gap != IDLE_GAP) gap_n = gap + 8'd1;
        // The comma registered on the grant edge itself is the last one of the gap.
        if (link_en && (|req) && gap >= IDLE_GAP - 8'd1) begin
          arb_take = 1'b1;
          grant_n  = arb_gnt;
          rem_n    = arb_gnt[1] ? len1 : len0;
          state_n  = ST_HDR0;
        end
      end
      ST_HDR0: begin
        tx_data_n = HDR_SYNC;
        tx_k_n    = 1'b0;
        state_n   = ST_HDR1;
      end
      ST_HDR1: begin
        tx_data_n = TAG_BASE + {7'd0, grant[1]};
        tx_k_n    = 1'b0;
        state_n   = ST_LEN;
      end
      ST_LEN: begin
        tx_data_n = rem;
        tx_k_n    = 1'b0;
        if (rem == 8'd0) begin
          frame_done_n = grant;
          gap_n        = 8'd0;
          state_n      = ST_IDLE;
        end else begin
          state_n = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        tx_k_n     = 1'b0;
        tx_data_n  = beat_ok ? (grant[1] ? s_data1 : s_data0) : PAD_BYTE;
        underrun_n = !beat_ok;
        rem_n      = rem - 8'd1;
        if (rem == 8'd1) begin
          frame_done_n = grant;
          gap_n        = 8'd0;
          state_n      = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rem        <= 8'd0;
      gap        <= 8'd0;
      grant      <= 2'b00;
      tx_data    <= COMMA_8B;
      tx_k       <= 1'b1;
      frame_done <= 2'b00;
      underrun   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      rem        <= rem_n;
      gap        <= gap_n;
      grant      <= grant_n;
      tx_data    <= tx_data_n;
      tx_k       <= tx_k_n;
      frame_done <= frame_done_n;
      underrun   <= underrun_n;
      busy       <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_lvds_tx_frame_sched.sv
// tb/tb_lvds_tx_frame_sched.sv - randomized self-checking bench for lvds_tx_frame_sched
// The reference model tracks the link as a queue of pending header symbols plus a payload count.
module tb_lvds_tx_frame_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       link_en = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] len0 = 8'd0, len1 = 8'd0;
  logic [7:0] s_data0 = 8'd0, s_data1 = 8'd0;
  logic [1:0] s_valid = 2'b00;
  logic [1:0] s_ready, grant, frame_done;
  logic       underrun, tx_k, busy;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  lvds_tx_frame_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .link_en    (link_en),
    .req        (req),
    .len0       (len0),
    .len1       (len1),
    .s_data0    (s_data0),
    .s_data1    (s_data1),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .grant      (grant),
    .frame_done (frame_done),
    .underrun   (underrun),
    .tx_data    (tx_data),
    .tx_k       (tx_k),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] hdr_q[$];
  int         pay_left, cur_ch, gap_cnt, last_ch, n_resets;
  bit         started;
  logic [1:0] want;
  logic [7:0] e_data;
  logic       e_k, e_ur, e_busy;
  logic [1:0] e_grant, e_fd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input int ch);
    return (ch == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic void model_reset();
    hdr_q.delete();
    pay_left = 0;
    cur_ch   = 0;
    gap_cnt  = 0;
    last_ch  = 1;
    e_data   = 8'hBC;
    e_k      = 1'b1;
    e_ur     = 1'b0;
    e_busy   = 1'b0;
    e_grant  = 2'b00;
    e_fd     = 2'b00;
  endfunction

  function automatic logic [1:0] model_ready();
    return (hdr_q.size() == 0 && pay_left > 0) ? onehot(cur_ch) : 2'b00;
  endfunction

  // Predicts the outputs registered on the coming edge from the inputs now being driven.
  function automatic void model_step();
    bit         is_last = 0;
    logic       v;
    logic [7:0] l;
    started = 0;
    e_k  = 1'b0;
    e_ur = 1'b0;
    e_fd = 2'b00;
    if (hdr_q.size() > 0) begin
      e_data  = hdr_q.pop_front();
      is_last = (hdr_q.size() == 0 && pay_left == 0);
    end else if (pay_left > 0) begin
      v        = s_valid[cur_ch];
      e_data   = v ? (cur_ch == 1 ? s_data1 : s_data0) : 8'h00;
      e_ur     = !v;
      pay_left = pay_left - 1;
      is_last  = (pay_left == 0);
    end else begin
      e_data  = 8'hBC;
      e_k     = 1'b1;
      gap_cnt = gap_cnt + 1;
      if (gap_cnt >= 16 && link_en && req != 2'b00) begin
        cur_ch   = (req == 2'b11) ? 1 - last_ch : (req[1] ? 1 : 0);
        last_ch  = cur_ch;
        l        = (cur_ch == 1) ? len1 : len0;
        hdr_q.push_back(8'hEE);
        hdr_q.push_back(8'h33 + 8'(cur_ch));
        hdr_q.push_back(l);
        pay_left = int'(l);
        started  = 1;
      end
    end
    if (is_last) begin
      e_fd    = onehot(cur_ch);
      gap_cnt = 0;
    end
    e_busy  = (hdr_q.size() > 0 || pay_left > 0);
    e_grant = (e_busy || is_last) ? onehot(cur_ch) : 2'b00;
  endfunction

  function automatic logic [7:0] rand_len();
    int r;
    r = $urandom_range(0, 15);
    return (r == 0) ? 8'd255 : 8'(r % 7);
  endfunction

  task automatic drive(input int cyc);
    s_data0 = 8'($urandom);
    s_data1 = 8'($urandom);
    if (cyc < 30) begin
      req = 2'b00; link_en = 1'b1;
      s_valid = 2'($urandom); len0 = rand_len(); len1 = rand_len();
    end else if (cyc < 200) begin
      req = 2'b11; link_en = 1'b1; s_valid = 2'b11; len0 = 8'd2; len1 = 8'd2;
    end else if (cyc < 300) begin
      req = 2'b01; link_en = 1'b0; s_valid = 2'b11; len0 = rand_len(); len1 = rand_len();
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (!want[n] && $urandom_range(0, 7) == 0) want[n] = 1'b1;
      end
      req     = want;
      link_en = ($urandom_range(0, 15) != 0);
      s_valid = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      len0    = rand_len();
      len1    = rand_len();
    end
  endtask

  task automatic compare_all();
    check_eq("tx_data", 32'(tx_data), 32'(e_data));
    check_eq("tx_k", 32'(tx_k), 32'(e_k));
    check_eq("grant", 32'(grant), 32'(e_grant));
    check_eq("frame_done", 32'(frame_done), 32'(e_fd));
    check_eq("underrun", 32'(underrun), 32'(e_ur));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("s_ready", 32'(s_ready), 32'(model_ready()));
  endtask

  initial begin
    want     = 2'b00;
    n_resets = 0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    drive(0);
    model_step();
    for (int cyc = 1; cyc < 8000; cyc++) begin
      @(negedge clk);
      compare_all();
      if (!rst_n) begin
        rst_n = 1'b1;
        drive(cyc);
        model_step();
      end else if (cyc >= 300 && n_resets < 5 && hdr_q.size() == 0 && pay_left > 1 &&
                   $urandom_range(0, 31) == 0) begin
        n_resets++;
        rst_n = 1'b0;
        model_reset();
      end else begin
        drive(cyc);
        model_step();
        if (started && cyc >= 300) want[cur_ch] = 1'b0;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lvds_tx_frame_sched.md
Name: lvds_tx_frame_sched

Overview:
- Frame scheduler in front of the 8b/10b encoder and LVDS serializer on the TX link.
- Shares the single serial link between two byte-stream requesters using round-robin arbitration.
- Wraps each granted payload in a fixed header (0xEE, channel tag, length) and fills the gaps between frames with K28.5 comma (0xBC, k=1) so the receiver word aligner stays locked.
- Drives the encoder's datain/kin inputs directly, one symbol per clk.

Parameters:
- IDLE_GAP, 8'd16, minimum comma symbols between frames, including after reset; range 1..255.
- HDR_SYNC, 8'hEE, first header byte.
- TAG_BASE, 8'h33, channel tag byte; channel n sends TAG_BASE+n.
- PAD_BYTE, 8'h00, substituted payload byte on source underrun.
- COMMA_8B, 8'hBC, idle symbol, sent with tx_k=1.

Ports:
- clk  in  1  symbol clock (PLL c0, same clock as the encoder).
- rst_n  in  1  asynchronous active-low reset.
- link_en  in  1  link usable (serializer locked and startup delay done); sampled only in IDLE.
- req  in  2  per-channel frame request, level; must be held until grant.
- len0, len1  in  8  payload length in bytes per channel; sampled on the grant cycle; 0 is legal.
- s_data0, s_data1  in  8  payload byte per channel.
- s_valid  in  2  payload byte valid per channel.
- s_ready  out  2  payload byte accepted this cycle (valid & ready = transfer).
- grant  out  2  one-hot; high from grant cycle through the last frame symbol.
- frame_done  out  2  one-cycle pulse on the cycle the last frame symbol is driven.
- underrun  out  1  one-cycle pulse for each PAD_BYTE inserted.
- tx_data  out  8  symbol to the encoder datain.
- tx_k  out  1  control-symbol flag to the encoder kin.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - State IDLE, gap counter 0.
  - tx_data=COMMA_8B, tx_k=1.
  - grant, s_ready, frame_done, underrun, busy all 0.
  - Round-robin pointer favours channel 0.
- All outputs except s_ready are registered. s_ready is combinational: (state==PAYLOAD) & grant[n] & remaining>0.
- IDLE:
  - Drives a comma every cycle; gap counter saturates at IDLE_GAP.
  - Grant is issued when gap>=IDLE_GAP, link_en=1 and some req bit is set.
  - Priority goes to the channel not served last. Simultaneous requests after reset give channel 0 first.
  - Grant cycle: grant[n] set, len latched into the remaining counter, move to HDR0.
- HDR0: tx_data=HDR_SYNC, tx_k=0.
- HDR1: tx_data=TAG_BASE+n, tx_k=0.
- LEN: tx_data=latched length, tx_k=0. If length==0, this is the last symbol: frame_done pulses, then go to IDLE.
- PAYLOAD, once per cycle:
  - If s_valid[n], the byte is accepted and appears on tx_data at the next edge (1-cycle latency).
  - Otherwise PAD_BYTE is sent and underrun pulses.
  - remaining decrements either way, so frame length is deterministic.
  - The symbol driven when remaining reaches 1 is the last one: frame_done[n] pulses, grant clears the following cycle, gap counter resets to 0, go to IDLE.
- Symbol sequence for length L: 3 header symbols, then exactly L payload symbols, then at least IDLE_GAP commas.
- Boundary rules:
  - A req drop mid-frame is ignored; the frame completes.
  - link_en falling mid-frame does not abort the frame; it only blocks new grants.
  - len changing after the grant cycle has no effect.
  - L=255: the 8-bit remaining counter must not wrap.
  - Reset mid-frame returns to IDLE immediately with comma output. The partial frame is discarded by the receiver (no trailing check).
  - Both req asserted continuously: frames strictly alternate 0,1,0,1.

Decomposition:
- Shared package lvds_link_pkg holds:
  - state encoding (IDLE, HDR0, HDR1, LEN, PAYLOAD);
  - COMMA_8B, HDR_SYNC, TAG_BASE;
  - the channel-count constant.
- The receiver-side deframer reuses the same package.
- One sub-module: rr_arb2, a two-requester round-robin arbiter with a last-served pointer, updated only on the grant cycle.

Test Plan:
- Reset then idle: rst_n released, req=0 -> tx_data=0xBC with tx_k=1 every cycle; busy=0.
- Single frame: link_en=1, req=01, len0=4, s_valid always 1, data 0x10..0x13.
  - Expect tx_data EE,33,04,10,11,12,13 with tx_k=0.
  - frame_done[0] on 0x13, then 16 commas minimum.
- Round-robin: req=11 held, len0=len1=2.
  - Tags alternate 0x33,0x34,0x33; the gap between frames is exactly 16 commas.
- Underrun: len1=3, s_valid[1] low on the 2nd payload cycle.
  - Payload d0,00,d1; underrun pulses once.
  - s_ready/valid handshake count = 2.
- Zero length and gating: len0=0 gives EE,33,00 and then commas. With link_en=0 and req=01, no grant and commas only.
- Reset mid-frame: assert rst_n low during PAYLOAD of a len=8 frame.
  - Next cycle tx_data=0xBC, tx_k=1, grant=0.
  - After release, 16 commas precede the next header.
